// File: rtl/rmii_pkg.sv
// rmii_pkg: shared RMII receive states and CRC-32 constants
package rmii_pkg;
    typedef enum logic [1:0] {
        IDLE,
        PREAMBLE,
        DATA,
        DROP
    } rx_state_t;
    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
    localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
    localparam logic [1:0]  PRE_DIBIT   = 2'b01;
    localparam logic [1:0]  SFD_DIBIT   = 2'b11;
endpackage

// File: rtl/crc32_d2.sv
// crc32_d2: reflected CRC-32 advanced by one dibit, bit 0 first
module crc32_d2
    import rmii_pkg::*;
(
    input  logic [31:0] crc_i,
    input  logic [1:0]  dibit_i,
    output logic [31:0] crc_o
);
    logic [31:0] crc_mid;
    // two serial LFSR steps, earlier wire bit first
    always_comb begin
        crc_mid = (crc_i >> 1) ^ ((crc_i[0] ^ dibit_i[0]) ? CRC_POLY : 32'h0);
        crc_o   = (crc_mid >> 1) ^ ((crc_mid[0] ^ dibit_i[1]) ? CRC_POLY : 32'h0);
    end
endmodule

// File: rtl/rmii_rx_frame.sv
// rmii_rx_frame: RMII receive decoder - preamble/SFD strip, byte assembly, FCS and length check
module rmii_rx_frame
    import rmii_pkg::*;
#(
    parameter int unsigned MAX_LEN = 1522,
    parameter int unsigned MIN_LEN = 64
) (
    input  logic        clk_50_mhz,
    input  logic        rst_n,
    input  logic        crs_dv,
    input  logic [1:0]  rx_d,
    input  logic        rx_er,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        rx_sof,
    output logic        rx_done,
    output logic        rx_crc_ok,
    output logic        rx_phy_err,
    output logic        rx_align_err,
    output logic        rx_len_err,
    output logic [10:0] rx_len
);
    rx_state_t   state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [1:0]  idx_q, idx_d;
    logic [7:0]  sr_q, sr_d;
    logic [31:0] crc_q, crc_d, crc_next;
    logic [10:0] len_q, len_d;
    logic        pend_q, pend_d;
    logic        first_q, first_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        sof_q, sof_d;
    logic        done_q, done_d;
    logic        crc_ok_q, crc_ok_d;
    logic        phy_q, phy_d;
    logic        align_q, align_d;
    logic        len_err_q, len_err_d;

    crc32_d2 u_crc (
        .crc_i   (crc_q),
        .dibit_i (rx_d),
        .crc_o   (crc_next)
    );

    // state and datapath registers, cleared asynchronously
    always_ff @(posedge clk_50_mhz or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            sr_q      <= '0;
            crc_q     <= CRC_INIT;
            len_q     <= '0;
            pend_q    <= 1'b0;
            first_q   <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            sof_q     <= 1'b0;
            done_q    <= 1'b0;
            crc_ok_q  <= 1'b0;
            phy_q     <= 1'b0;
            align_q   <= 1'b0;
            len_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            sr_q      <= sr_d;
            crc_q     <= crc_d;
            len_q     <= len_d;
            pend_q    <= pend_d;
            first_q   <= first_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            sof_q     <= sof_d;
            done_q    <= done_d;
            crc_ok_q  <= crc_ok_d;
            phy_q     <= phy_d;
            align_q   <= align_d;
            len_err_q <= len_err_d;
        end
    end

    // next state: preamble hunt, dibit assembly, CRS-toggle aware frame end
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        sr_d      = sr_q;
        crc_d     = crc_q;
        len_d     = len_q;
        pend_d    = pend_q;
        first_d   = first_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        sof_d     = 1'b0;
        done_d    = 1'b0;
        crc_ok_d  = crc_ok_q;
        phy_d     = phy_q;
        align_d   = align_q;
        len_err_d = len_err_q;
        case (state_q)
            IDLE: begin
                if (crs_dv && rx_d == PRE_DIBIT) begin
                    state_d = PREAMBLE;
                    cnt_d   = 3'd1;
                end
            end
            PREAMBLE: begin
                if (!crs_dv) begin
                    state_d = DROP;
                end else if (rx_d == PRE_DIBIT) begin
                    cnt_d = (cnt_q == 3'd7) ? cnt_q : cnt_q + 3'd1;
                end else if (rx_d == SFD_DIBIT && cnt_q >= 3'd2) begin
                    state_d   = DATA;
                    idx_d     = '0;
                    crc_d     = CRC_INIT;
                    len_d     = '0;
                    pend_d    = 1'b0;
                    first_d   = 1'b1;
                    crc_ok_d  = 1'b0;
                    phy_d     = 1'b0;
                    align_d   = 1'b0;
                    len_err_d = 1'b0;
                end else begin
                    state_d = DROP;
                end
            end
            DATA: begin
                phy_d = phy_q | rx_er;
                // a low sample ends the frame at a byte boundary or when it follows a toggled dibit
                if (!crs_dv && (idx_q == 2'd0 || pend_q)) begin
                    state_d   = IDLE;
                    done_d    = 1'b1;
                    align_d   = pend_q;
                    crc_ok_d  = (crc_q == CRC_RESIDUE);
                    len_err_d = (32'(len_q) < MIN_LEN) || (32'(len_q) > MAX_LEN);
                end else begin
                    pend_d = !crs_dv;
                    sr_d   = {rx_d, sr_q[7:2]};
                    crc_d  = crc_next;
                    idx_d  = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        valid_d = 1'b1;
                        data_d  = {rx_d, sr_q[7:2]};
                        sof_d   = first_q;
                        first_d = 1'b0;
                        len_d   = (len_q == 11'h7FF) ? len_q : len_q + 11'd1;
                    end
                end
            end
            DROP: begin
                if (!crs_dv) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign rx_data      = data_q;
    assign rx_valid     = valid_q;
    assign rx_sof       = sof_q;
    assign rx_done      = done_q;
    assign rx_crc_ok    = crc_ok_q;
    assign rx_phy_err   = phy_q;
    assign rx_align_err = align_q;
    assign rx_len_err   = len_err_q;
    assign rx_len       = len_q;
endmodule

// File: tb/tb_rmii_rx_frame.sv
// tb_rmii_rx_frame: directed frame-level checks of the RMII receive decoder
module tb_rmii_rx_frame;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        crs_dv = 1'b0;
    logic [1:0]  rx_d = 2'b00;
    logic        rx_er = 1'b0;
    logic [7:0]  rx_data;
    logic        rx_valid, rx_sof, rx_done, rx_crc_ok, rx_phy_err, rx_align_err, rx_len_err;
    logic [10:0] rx_len;

    int tests = 0;
    int fails = 0;
    logic [7:0] frm [0:127];
    logic [7:0] cap [0:255];
    int nvalid, sof_cnt, sof_pos, done_cnt;
    logic s_crc, s_phy, s_align, s_len_err;
    logic [10:0] s_len;

    rmii_rx_frame dut (
        .clk_50_mhz   (clk),
        .rst_n        (rst_n),
        .crs_dv       (crs_dv),
        .rx_d         (rx_d),
        .rx_er        (rx_er),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_sof       (rx_sof),
        .rx_done      (rx_done),
        .rx_crc_ok    (rx_crc_ok),
        .rx_phy_err   (rx_phy_err),
        .rx_align_err (rx_align_err),
        .rx_len_err   (rx_len_err),
        .rx_len       (rx_len)
    );

    always #10 clk = ~clk;

    // capture bytes and end-of-frame status away from the active edge
    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid) begin
                if (nvalid < 256) cap[nvalid] = rx_data;
                if (rx_sof) begin
                    sof_cnt++;
                    sof_pos = nvalid;
                end
                nvalid++;
            end
            if (rx_done) begin
                done_cnt++;
                s_crc     = rx_crc_ok;
                s_phy     = rx_phy_err;
                s_align   = rx_align_err;
                s_len_err = rx_len_err;
                s_len     = rx_len;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear();
        nvalid = 0; sof_cnt = 0; sof_pos = -1; done_cnt = 0;
        s_crc = 1'bx; s_phy = 1'bx; s_align = 1'bx; s_len_err = 1'bx; s_len = 'x;
    endtask

    function automatic logic [31:0] crc_bytes(input int n);
        logic [31:0] c = 32'hFFFF_FFFF;
        for (int i = 0; i < n; i++) begin
            c ^= {24'h0, frm[i]};
            for (int j = 0; j < 8; j++) c = c[0] ? (c >> 1) ^ 32'hEDB8_8320 : c >> 1;
        end
        return c;
    endfunction

    task automatic build();
        logic [31:0] fcs;
        for (int i = 0; i < 60; i++) frm[i] = 8'(i);
        fcs = ~crc_bytes(60);
        for (int i = 0; i < 4; i++) frm[60 + i] = fcs[8*i +: 8];
    endtask

    task automatic drive(input logic dv, input logic [1:0] d, input logic er);
        @(negedge clk);
        crs_dv = dv; rx_d = d; rx_er = er;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int k = 0; k < 4; k++) drive(1'b1, b[2*k +: 2], 1'b0);
    endtask

    task automatic send_pre();
        repeat (7) send_byte(8'h55);
        send_byte(8'hD5);
    endtask

    task automatic send_body(input int n, input int er_byte, input int tog_byte);
        for (int i = 0; i < n; i++)
            for (int k = 0; k < 4; k++)
                drive(!(i == tog_byte && k == 2), frm[i][2*k +: 2], i == er_byte && k == 1);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 2'b00, 1'b0);
    endtask

    function automatic int data_mism(input int n);
        int m = 0;
        for (int i = 0; i < n; i++) if (cap[i] !== frm[i]) m++;
        return m;
    endfunction

    initial begin
        clear();
        build();
        repeat (3) @(negedge clk);
        check("reset_data", 32'(rx_data), 32'h0);
        check("reset_valid", 32'(rx_valid), 32'h0);
        check("reset_done", 32'(rx_done), 32'h0);
        check("reset_len", 32'(rx_len), 32'h0);
        check("reset_flags", {28'h0, rx_crc_ok, rx_phy_err, rx_align_err, rx_len_err}, 32'h0);
        rst_n = 1'b1;
        idle(2);

        clear();
        send_pre(); send_body(64, -1, -1); idle(4);
        check("good_nvalid", nvalid, 64);
        check("good_sof_cnt", sof_cnt, 1);
        check("good_sof_pos", sof_pos, 0);
        check("good_data", data_mism(64), 0);
        check("good_done", done_cnt, 1);
        check("good_crc", 32'(s_crc), 32'h1);
        check("good_len", 32'(s_len), 32'd64);
        check("good_errs", {29'h0, s_phy, s_align, s_len_err}, 32'h0);
        check("good_len_hold", 32'(rx_len), 32'd64);

        clear();
        send_pre(); send_body(64, -1, -1); idle(1);
        send_pre(); send_body(64, -1, -1); idle(4);
        check("b2b_done", done_cnt, 2);
        check("b2b_nvalid", nvalid, 128);
        check("b2b_crc", 32'(s_crc), 32'h1);

        clear();
        frm[10] ^= 8'h08;
        send_pre(); send_body(64, -1, -1); idle(4);
        check("flip_done", done_cnt, 1);
        check("flip_crc", 32'(s_crc), 32'h0);
        check("flip_len", 32'(s_len), 32'd64);
        build();

        clear();
        send_pre(); send_body(64, 20, -1); idle(4);
        check("phy_err", 32'(s_phy), 32'h1);
        check("phy_nvalid", nvalid, 64);
        check("phy_crc", 32'(s_crc), 32'h1);

        clear();
        send_pre(); send_body(64, -1, 63); idle(4);
        check("tog_done", done_cnt, 1);
        check("tog_len", 32'(s_len), 32'd64);
        check("tog_align", 32'(s_align), 32'h0);
        check("tog_crc", 32'(s_crc), 32'h1);

        clear();
        send_pre(); send_body(63, -1, -1);
        drive(1'b1, frm[63][1:0], 1'b0);
        drive(1'b1, frm[63][3:2], 1'b0);
        drive(1'b0, frm[63][5:4], 1'b0);
        idle(4);
        check("align_done", done_cnt, 1);
        check("align_err", 32'(s_align), 32'h1);
        check("align_len", 32'(s_len), 32'd63);
        check("align_nvalid", nvalid, 63);
        check("align_len_err", 32'(s_len_err), 32'h1);

        clear();
        send_byte(8'h55); send_byte(8'h55);
        drive(1'b1, 2'b00, 1'b0);
        repeat (3) drive(1'b1, 2'b01, 1'b0);
        drive(1'b1, 2'b11, 1'b0);
        send_byte(8'hAA); send_byte(8'h3C);
        idle(4);
        check("badpre_nvalid", nvalid, 0);
        check("badpre_done", done_cnt, 0);

        clear();
        send_pre(); send_body(30, -1, -1);
        drive(1'b1, frm[30][1:0], 1'b0);
        check("mid_len_pre", 32'(rx_len), 32'd30);
        rst_n = 1'b0; crs_dv = 1'b0; rx_d = 2'b00;
        #1;
        check("mid_rst_data", 32'(rx_data), 32'h0);
        check("mid_rst_len", 32'(rx_len), 32'h0);
        check("mid_rst_valid", 32'(rx_valid), 32'h0);
        check("mid_rst_done", 32'(rx_done), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(4);
        check("mid_no_done", done_cnt, 0);
        clear();
        send_pre(); send_body(64, -1, -1); idle(4);
        check("mid2_done", done_cnt, 1);
        check("mid2_crc", 32'(s_crc), 32'h1);
        check("mid2_len", 32'(s_len), 32'd64);
        check("mid2_data", data_mism(64), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/rmii_rx_frame.md
# rmii_rx_frame

Receive-side RMII frame decoder for the 100 Mbit/s Ethernet path; the peer of the MAC transmit logic that drives `tx_d_*`/`tx_e_*`. Samples `crs_dv`/`rx_d`/`rx_er` on the 50 MHz RMII reference clock and strips preamble/SFD. Assembles dibits LSB-first into bytes and checks the Ethernet FCS. Used in the MAC RX datapath and instanced in the top-level bench to check frames the MAC transmits.

## Interface

Parameters:
- `MAX_LEN`, 1522: frame length (bytes after SFD, FCS included) above which `rx_len_err` is set.
- `MIN_LEN`, 64: frame length below which `rx_len_err` is set.

Ports:
- `clk_50_mhz`  in  1  RMII reference clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `crs_dv`  in  1  RMII carrier sense / data valid.
- `rx_d`  in  2  RMII receive dibit; bit 0 earlier in the wire bit order.
- `rx_er`  in  1  PHY receive error.
- `rx_data`  out  8  assembled byte; valid when `rx_valid`=1.
- `rx_valid`  out  1  one-cycle pulse per byte.
- `rx_sof`  out  1  high with `rx_valid` on the first byte after SFD.
- `rx_done`  out  1  one-cycle pulse at frame end; status outputs valid in the same cycle.
- `rx_crc_ok`  out  1  FCS residue correct.
- `rx_phy_err`  out  1  `rx_er` seen during DATA.
- `rx_align_err`  out  1  frame ended on a non-byte boundary.
- `rx_len_err`  out  1  length < `MIN_LEN` or > `MAX_LEN`.
- `rx_len`  out  11  byte count, FCS included; saturates at 2047.

## Operation

- States: IDLE, PREAMBLE, DATA, DROP.
- IDLE: `crs_dv`=1 with `rx_d`=01 -> PREAMBLE. Any other value stays in IDLE.
- PREAMBLE: `rx_d`=01 counts preamble dibits (3-bit saturating).
  - `rx_d`=11 with count >= 2 is the SFD -> DATA. Dibit index, CRC register (0xFFFFFFFF) and length counter are cleared.
  - `rx_d`=11 with count < 2, `rx_d`=00 or 10, or `crs_dv`=0 -> DROP. No `rx_done` is generated.
- DATA:
  - Each cycle shifts the dibit into `byte_sr[7:6]`, i.e. LSB-first assembly.
  - Dibit index 0..3 wraps. On index 3 the byte is emitted and `rx_len` increments.
  - The CRC updates every dibit. Algorithm: reflected CRC-32, poly 0xEDB88320, no final XOR. It covers all bytes after SFD, FCS included.
- Frame end:
  - `crs_dv`=0 sampled at dibit index 0 -> `rx_done`, return to IDLE. That dibit is discarded.
  - `crs_dv`=0 at index 1..3 is RMII CRS toggling: the dibit is taken as data.
  - If `crs_dv` is also 0 on the next cycle, the frame ends with `rx_align_err`=1 and the partial byte is discarded.
- `rx_crc_ok`: 1 when the CRC register equals 0xDEBB20E3 at frame end.
- `rx_phy_err`: sticky within a frame. It is set by `rx_er`=1 on any DATA cycle, including a cycle where `crs_dv`=0.
- DROP: wait until `crs_dv`=0, then go to IDLE.

## Timing

- Byte path: `rx_valid`/`rx_data` are registered one cycle after the 4th dibit is sampled. One byte every 4 cycles at most.
- End path: `rx_done` is registered one cycle after the terminating `crs_dv`=0 sample. Status outputs hold until the next SFD, then clear.
- Reset values (asynchronous):
  - state IDLE;
  - `rx_data`=0x00;
  - all pulses and flags 0;
  - `rx_len`=0;
  - CRC register 0xFFFFFFFF.
- Reset mid-frame: returns to IDLE immediately. No `rx_done` is produced for the aborted frame.
- Back-to-back frames: one `crs_dv`=0 cycle between frames is sufficient. `rx_done` of frame N and SFD detection of frame N+1 may be 2 cycles apart.
- Length: above 2047 `rx_len` saturates, `rx_len_err`=1, and bytes continue to be emitted.

## Structure

- Package `rmii_pkg`:
  - `rx_state_t` enum;
  - `CRC_INIT`=32'hFFFF_FFFF, `CRC_RESIDUE`=32'hDEBB_20E3, `CRC_POLY`=32'hEDB8_8320;
  - `PRE_DIBIT`=2'b01, `SFD_DIBIT`=2'b11.
- Sub-module `crc32_d2`: combinational 2-bit-per-step reflected CRC update, `crc_next = f(crc, dibit)`. Reused by the TX side.

## Test plan

- 64-byte frame: 7×0x55, 0xD5, 60 payload bytes 0x00..0x3B, then valid FCS -> 64 `rx_valid` pulses, `rx_sof` on 0x00, `rx_done` with `rx_crc_ok`=1, `rx_len`=64, all error flags 0.
- Same frame with payload byte 10 bit 3 flipped -> `rx_crc_ok`=0, `rx_len`=64.
- `rx_er`=1 for one cycle in byte 20 -> `rx_phy_err`=1. All 64 bytes still emitted.
- CRS toggle: `crs_dv`=0 at index 2 of byte 63, then 1 -> no end, `rx_len`=64, `rx_align_err`=0. Ending with `crs_dv`=0 at index 2 twice -> `rx_align_err`=1, `rx_len`=63.
- Bad preamble: 0x55 0x55 then dibit 00 -> DROP, no `rx_valid`, no `rx_done`.
- Reset mid-frame:
  - Step: `rst_n`=0 during byte 30, then a full valid 64-byte frame.
  - Required: outputs read 0 during reset and the aborted frame gives no `rx_done`.
  - Required: the second frame is received with `rx_crc_ok`=1 and `rx_len`=64.
